serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 3, giving the operand and result width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port a, input, N bits: minuend, unsigned.
REQ-006 The block SHALL have port b, input, N bits: subtrahend, unsigned.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new result.
REQ-009 The block SHALL have port resta, output, N bits: the result (a - b) mod 2^N.
REQ-010 The block SHALL have port borrow, output, 1 bit: high when a < b (final borrow out).

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 Transitions SHALL be:
- IDLE -> RUN on start=1.
- RUN -> DONE after exactly N RUN cycles.
- DONE -> RUN on start=1, else DONE -> IDLE.
REQ-013 On accepting start, the block SHALL latch a and b into internal shift registers, clear the internal borrow, and load the bit counter with 0.
REQ-014 Each RUN cycle SHALL process one bit, LSB first, with i = counter, x = a_i, y = b_i, c = internal borrow:
- d = x ^ y ^ c
- c_next = (~x & y) | (~(x ^ y) & c)
- d is shifted into the MSB of an internal result register (right shift), so it holds (a - b) mod 2^N after N cycles.
REQ-015 a and b SHALL NOT be sampled after acceptance; changes during RUN have no effect on the operation in progress.
REQ-016 start asserted while in RUN SHALL be ignored; no queuing.
REQ-017 On the RUN -> DONE transition, the block SHALL copy the internal result register to resta and the final borrow to borrow in the same edge.
REQ-018 done SHALL be high only while in DONE, i.e. for exactly one cycle; it is first high in the cycle following the (N+1)th rising edge counted from, and including, the edge that sampled start.
REQ-019 resta and borrow SHALL stay unchanged outside the update of REQ-017, including throughout a subsequent RUN; partial results SHALL never appear on them.
REQ-020 start=1 during DONE SHALL be accepted (back-to-back operation), with done still pulsing in that cycle; throughput is one result per N+1 cycles.
REQ-021 busy SHALL be high exactly during the N RUN cycles and low in IDLE and DONE.
REQ-022 The arithmetic SHALL be unsigned modulo 2^N; borrow = 1 iff a < b; a == b SHALL give resta = 0, borrow = 0.
REQ-023 The bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, resta, borrow, the counter and all internal registers to 0.
REQ-025 rst SHALL take priority over start and over any operation in progress; an aborted operation SHALL produce no done pulse and SHALL NOT update resta or borrow.
REQ-026 With rst and start both high at the same edge, the block SHALL go to IDLE and not accept start.

Verification (N=3)
REQ-027 The bench SHALL cover these directed scenarios:
- a=5, b=3, start pulse: busy high for 3 cycles, then done 1 cycle, resta=2, borrow=0.
- a=2, b=5: resta=5, borrow=1; then a=7, b=7: resta=0, borrow=0.
- a=0, b=1, then start held high: resta=7, borrow=1; second operation begins in the DONE cycle; done pulses every 4 cycles.
- start again, and a/b changed, 1 cycle after acceptance of a=1, b=1: both ignored; resta=0, borrow=0.
- rst=1 in the 2nd RUN cycle of a=3, b=2: IDLE next cycle, no done, resta/borrow remain at their reset value of 0.
- Exhaustive a, b over 0..7 checked against a reference (a - b) mod 8 and borrow = (a < b).

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// master drives operands and start; slave returns status and result.
interface serial_subtractor_if #(
  parameter int N = 3
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] resta;
  logic         borrow;

  modport master (
    output start, a, b,
    input  busy, done, resta, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, resta, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per cycle.
// Result and borrow only change when an operation completes.
module serial_subtractor #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  resta_q, resta_d;
  logic          c_q, c_d;
  logic          borrow_q, borrow_d;

  logic x, y, dbit, cnext;

  // State and datapath registers; reset beats everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      c_q      <= 1'b0;
      resta_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      c_q      <= c_d;
      resta_q  <= resta_d;
      borrow_q <= borrow_d;
    end
  end

  // Next state, one full-subtractor step per RUN cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    c_d      = c_q;
    resta_d  = resta_q;
    borrow_d = borrow_q;

    x     = a_q[0];
    y     = b_q[0];
    dbit  = x ^ y ^ c_q;
    cnext = (~x & y) | (~(x ^ y) & c_q);

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          r_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        r_d = {dbit, r_q[N-1:1]};
        c_d = cnext;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          resta_d  = {dbit, r_q[N-1:1]};
          borrow_d = cnext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.resta  = resta_q;
  assign bus.borrow = borrow_q;

endmodule
